// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor: one SLICE-bit ripple slice per stage,
// carry registered between stages, valid/ready handshake and flush.
module pipelined_addsub #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int STAGES = WIDTH / SLICE;

    logic                en;
    logic [STAGES-1:0]   v_q;
    logic [WIDTH-1:0]    r_q [STAGES];
    logic                c_q [STAGES];

    logic [WIDTH-1:0]    xs [STAGES];
    logic [WIDTH-1:0]    ys [STAGES];
    logic [WIDTH-1:0]    rs [STAGES];
    logic                cs [STAGES];

    logic [WIDTH-1:0]    r_d [STAGES];
    logic                c_d [STAGES];
    logic                ovf_d;
    logic                zero_d;

    assign en        = !out_valid || out_ready;
    assign in_ready  = en;
    assign out_valid = v_q[STAGES-1];
    assign sum       = r_q[STAGES-1];
    assign cout      = c_q[STAGES-1];

    // Stage 0 works straight from the ports; b is inverted once here.
    assign xs[0] = a;
    assign ys[0] = sub ? ~b : b;
    assign rs[0] = '0;
    assign cs[0] = sub | cin;

    generate
        if (STAGES > 1) begin : g_ops
            logic [WIDTH-1:0] x_q [STAGES-1];
            logic [WIDTH-1:0] y_q [STAGES-1];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < STAGES - 1; k++) begin
                        x_q[k] <= '0;
                        y_q[k] <= '0;
                    end
                end else if (en) begin
                    x_q[0] <= xs[0];
                    y_q[0] <= ys[0];
                    for (int k = 1; k < STAGES - 1; k++) begin
                        x_q[k] <= x_q[k-1];
                        y_q[k] <= y_q[k-1];
                    end
                end
            end

            for (genvar k = 1; k < STAGES; k++) begin : g_link
                assign xs[k] = x_q[k-1];
                assign ys[k] = y_q[k-1];
                assign rs[k] = r_q[k-1];
                assign cs[k] = c_q[k-1];
            end
        end
    endgenerate

    // Ripple each stage's slice; m tracks the carry into the current bit,
    // which after the last slice is the carry into the MSB.
    always_comb begin
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic [WIDTH-1:0] r;
        logic             c;
        logic             m;
        x = '0;
        y = '0;
        r = '0;
        c = 1'b0;
        m = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            x = xs[k];
            y = ys[k];
            r = rs[k];
            c = cs[k];
            for (int i = 0; i < SLICE; i++) begin
                m = c;
                r[k*SLICE+i] = x[k*SLICE+i] ^ y[k*SLICE+i] ^ c;
                c = (x[k*SLICE+i] & y[k*SLICE+i])
                  | (x[k*SLICE+i] & c)
                  | (y[k*SLICE+i] & c);
            end
            r_d[k] = r;
            c_d[k] = c;
        end
        ovf_d  = m ^ c;
        zero_d = (r == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q      <= '0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                r_q[k] <= '0;
                c_q[k] <= 1'b0;
            end
        end else begin
            if (flush) begin
                v_q <= '0;
            end else if (en) begin
                v_q[0] <= in_valid;
                for (int k = 1; k < STAGES; k++) begin
                    v_q[k] <= v_q[k-1];
                end
            end
            if (en) begin
                for (int k = 0; k < STAGES; k++) begin
                    r_q[k] <= r_d[k];
                    c_q[k] <= c_d[k];
                end
                overflow <= ovf_d;
                zero     <= zero_d;
            end
        end
    end

endmodule

// File: doc/pipelined_addsub.md
# pipelined_addsub

Parametrised, pipelined adder/subtractor for the 32-bit MIPS datapath, generalising the 4-bit ripple-carry adder to WIDTH bits split into SLICE-bit ripple slices, one slice per pipeline stage. Each stage adds one slice and registers its carry forward to the next stage, so the clock period is bounded by a SLICE-bit ripple rather than a WIDTH-bit ripple. The block sits between operand issue and writeback, with a valid/ready handshake on both sides and a flush input for pipeline squash.

## Interface
- WIDTH, 32, operand and result width; must be a multiple of SLICE.
- SLICE, 8, bits added per stage; STAGES = WIDTH/SLICE, and latency is STAGES cycles.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous squash of all in-flight operations.
- in_valid  in  1  operand beat is valid.
- in_ready  out  1  block accepts a beat this cycle.
- a, b  in  WIDTH  operands.
- cin  in  1  carry-in; used only when sub=0.
- sub  in  1  0: a+b+cin; 1: a+~b+1 (cin ignored).
- out_valid  out  1  result beat is valid.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of the MSB; for sub this is the no-borrow flag (1 when a>=b unsigned).
- overflow  out  1  signed overflow: carry into the MSB XOR carry out of the MSB.
- zero  out  1  sum == 0.

## Operation
- Global enable: en = !out_valid || out_ready. in_ready = en. All stage registers advance only when en=1.
- Stage k (0..STAGES-1) holds:
  - a valid bit;
  - the registered carry;
  - the result slices 0..k-1 computed so far;
  - the remaining operand slices k..STAGES-1, with b already inverted when sub=1.
- Stage 0 captures the inputs when in_valid && en. It inverts b if sub=1 and sets the initial carry to sub ? 1 : cin.
- Each stage ripples its SLICE bits with the full-adder equations s=x^y^c and co=xy|xc|yc, then passes the partial result and carry-out to the next stage.
- The last stage also records the carry into the MSB, which is needed for overflow.
- Outputs come from the final register stage. sum, cout, overflow and zero are registered and held stable while out_valid && !out_ready.
- Bubbles (invalid stages) are not collapsed; they advance with en like valid beats.
- flush=1: every valid bit is cleared at the next edge, and out_valid=0 the following cycle. Data registers may keep stale values. A beat presented on the same cycle as flush is dropped, even if in_ready=1.
- Reset (rst_n=0, asynchronous): all valid bits, sum, cout, overflow and zero go to 0. Reset asserted mid-operation discards all in-flight beats.

## Timing
- Latency: a beat accepted at edge t appears with out_valid=1 after edge t+STAGES-1, i.e. STAGES cycles after it is presented, when no stall occurs.
- Throughput: 1 beat/cycle while out_ready=1.
- Stall: out_valid=1 && out_ready=0 → en=0. in_ready drops combinationally in the same cycle, and all state, including outputs, holds.
- Simultaneous stall and flush: flush wins; valid bits clear regardless of en.
- Release of rst_n: in_ready=1 combinationally on the first cycle, because out_valid=0.
- in_ready depends combinationally on out_ready. No other input-to-output combinational path exists.

## Test plan
- Reset: rst_n=0 mid-stream with 3 beats in flight → out_valid=0, sum=0, cout=0, overflow=0, zero=0 immediately. No stale result appears after release.
- Add latency and carry chain (WIDTH=32, SLICE=8): a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 → exactly 4 cycles later sum=0x00000000, cout=1, overflow=0, zero=1. This exercises the carry crossing every slice boundary.
- Signed overflow and subtract:
  - a=0x7FFFFFFF, b=1, sub=0 → sum=0x80000000, overflow=1, cout=0.
  - a=5, b=7, sub=1 → sum=0xFFFFFFFE, cout=0, overflow=0.
  - a=7, b=7, sub=1, cin=0 → sum=0, zero=1, cout=1.
- Streaming with backpressure: 8 back-to-back random beats with out_ready toggling in a 1,0,0,1 pattern → results match the model in order, none lost or duplicated, and outputs are held constant while stalled.
- Flush: 4 beats in flight, then flush=1 for 1 cycle while in_valid=1 → no result from any of those 5 beats emerges. The next beat (a=1, b=2) yields sum=3 after 4 cycles.
- Parameter sweep: WIDTH=16/SLICE=4, WIDTH=32/SLICE=32 (single stage) and WIDTH=64/SLICE=16 with 1000 random beats each against a golden a±b model → all fields match and latency equals STAGES.
